// File: rtl/control_unit.sv
// control_unit: hardwired control sequencer for the 32-bit bus-based CPU.
// It fetches, decodes and executes one instruction at a time, one control
// step per clock. Every datapath strobe is decoded combinationally from the
// current step and the IR opcode. The block has no valid/ready handshake:
// the datapath obeys the strobes unconditionally in the cycle they are high.
// The current step is held in `state` so checkers can bind to it directly.
module control_unit (
    input  logic       clock,
    input  logic       clear,
    input  logic [4:0] ir_op,
    input  logic       con_ff,
    input  logic       stop,
    output logic       run,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       rin,
    output logic       rout,
    output logic       ba_out,
    output logic       c_out,
    output logic       pc_out,
    output logic       pc_in,
    output logic       inc_pc,
    output logic       ir_in,
    output logic       mar_in,
    output logic       mdr_in,
    output logic       mdr_out,
    output logic       read,
    output logic       write,
    output logic       y_in,
    output logic       z_in,
    output logic       zlo_out,
    output logic       hi_out,
    output logic       lo_out,
    output logic       con_in,
    output logic [4:0] ops
);

    // Control steps
    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;

    // Opcodes (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation selects
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    logic [3:0] state;
    logic [3:0] next_state;

    logic is_alu, is_imm, is_ldi, is_ld, is_st, is_br;
    logic is_jr, is_mfhi, is_mflo, is_halt;
    logic [4:0] alu_sel;

    assign is_alu  = (ir_op == OP_ADD) || (ir_op == OP_SUB) ||
                     (ir_op == OP_AND) || (ir_op == OP_OR);
    assign is_imm  = (ir_op == OP_ADDI) || (ir_op == OP_ANDI) || (ir_op == OP_ORI);
    assign is_ldi  = (ir_op == OP_LDI);
    assign is_ld   = (ir_op == OP_LD);
    assign is_st   = (ir_op == OP_ST);
    assign is_br   = (ir_op == OP_BR);
    assign is_jr   = (ir_op == OP_JR);
    assign is_mfhi = (ir_op == OP_MFHI);
    assign is_mflo = (ir_op == OP_MFLO);
    assign is_halt = (ir_op == OP_HALT);

    // ALU function for register and immediate arithmetic/logic ops
    always_comb begin
        alu_sel = ALU_NONE;
        case (ir_op)
            OP_ADD, OP_ADDI: alu_sel = ALU_ADD;
            OP_SUB:          alu_sel = ALU_SUB;
            OP_AND, OP_ANDI: alu_sel = ALU_AND;
            OP_OR,  OP_ORI:  alu_sel = ALU_OR;
            default:         alu_sel = ALU_NONE;
        endcase
    end

    // Step register; clear aborts any instruction immediately
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= S_RESET;
        else        state <= next_state;
    end

    // Step sequencing: each instruction ends by returning to T0
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = stop ? S_HALT : S_T1;
            S_T1:    next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3: begin
                if (is_halt)
                    next_state = S_HALT;
                else if (is_alu || is_imm || is_ldi || is_ld || is_st || is_br)
                    next_state = S_T4;
                else
                    next_state = S_T0;
            end
            S_T4:    next_state = S_T5;
            S_T5:    next_state = (is_ld || is_st || is_br) ? S_T6 : S_T0;
            S_T6:    next_state = (is_ld || is_st) ? S_T7 : S_T0;
            S_T7:    next_state = S_T0;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    // Strobe decode from the current step and opcode
    always_comb begin
        run = 1'b0;  gra = 1'b0;  grb = 1'b0;  grc = 1'b0;
        rin = 1'b0;  rout = 1'b0; ba_out = 1'b0; c_out = 1'b0;
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; ir_in = 1'b0;
        mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0;
        write = 1'b0; y_in = 1'b0; z_in = 1'b0; zlo_out = 1'b0;
        hi_out = 1'b0; lo_out = 1'b0; con_in = 1'b0; ops = ALU_NONE;
        case (state)
            S_T0: begin
                run = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            end
            S_T1: begin
                run = 1'b1; zlo_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
            end
            S_T2: begin
                run = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (is_alu || is_imm) begin
                    grb = 1'b1; rout = 1'b1; y_in = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                end else if (is_br) begin
                    gra = 1'b1; rout = 1'b1; con_in = 1'b1;
                end else if (is_jr) begin
                    gra = 1'b1; rout = 1'b1; pc_in = 1'b1;
                end else if (is_mfhi) begin
                    hi_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (is_mflo) begin
                    lo_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end
            end
            S_T4: begin
                run = 1'b1;
                if (is_alu) begin
                    grc = 1'b1; rout = 1'b1; ops = alu_sel; z_in = 1'b1;
                end else if (is_imm) begin
                    c_out = 1'b1; ops = alu_sel; z_in = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    c_out = 1'b1; ops = ALU_ADD; z_in = 1'b1;
                end else if (is_br) begin
                    pc_out = 1'b1; y_in = 1'b1;
                end
            end
            S_T5: begin
                run = 1'b1;
                if (is_alu || is_imm || is_ldi) begin
                    zlo_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (is_ld || is_st) begin
                    zlo_out = 1'b1; mar_in = 1'b1;
                end else if (is_br) begin
                    c_out = 1'b1; ops = ALU_ADD; z_in = 1'b1;
                end
            end
            S_T6: begin
                run = 1'b1;
                if (is_ld) begin
                    read = 1'b1; mdr_in = 1'b1;
                end else if (is_st) begin
                    // read stays low so the MDR captures the bus, not memory
                    gra = 1'b1; rout = 1'b1; mdr_in = 1'b1;
                end else if (is_br && con_ff) begin
                    zlo_out = 1'b1; pc_in = 1'b1;
                end
            end
            S_T7: begin
                run = 1'b1;
                if (is_ld) begin
                    mdr_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (is_st) begin
                    write = 1'b1;
                end
            end
            default: begin
                run = 1'b0;
            end
        endcase
    end

endmodule
